// File: rtl/dma_sched_pkg.sv
// Shared types and constants for the DDR ring-buffer command scheduler.
//   sched_state_t   : scheduler FSM states
//   grant_t         : round-robin grant encoding (GRANT_WR / GRANT_RD)
//   MAX_BURST_BYTES : largest legal burst length in bytes
package dma_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4
  } sched_state_t;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_t;

  localparam int unsigned MAX_BURST_BYTES = 4096;

endpackage

// File: rtl/ring_ptr.sv
// Ring-buffer pointer register with wrap.
//   clk, reset          : clock, synchronous active-high reset (pointer -> 0)
//   load                : load base_addr (has priority over advance)
//   advance             : move pointer forward by step, wrapping to base_addr
//   base_addr, end_addr : ring bounds, [base, end)
//   step                : advance amount in bytes
//   ptr                 : current pointer value
module ring_ptr
  import dma_sched_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH      = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      advance,
  input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [AXI_ADDR_WIDTH-1:0] end_addr,
  input  logic [LEN_WIDTH-1:0]      step,
  output logic [AXI_ADDR_WIDTH-1:0] ptr
);

  logic [AXI_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [AXI_ADDR_WIDTH:0]   sum;

  // One extra bit on the sum so a ring ending at the top of the address
  // space still compares correctly against end_addr.
  always_comb begin
    sum   = {1'b0, ptr_q} + (AXI_ADDR_WIDTH + 1)'(step);
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = base_addr;
    end else if (advance) begin
      ptr_d = (sum >= {1'b0, end_addr}) ? base_addr : sum[AXI_ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/dma_cmd_scheduler.sv
// DDR ring-buffer command scheduler in front of the DMA user command ports.
// Issues write bursts when the source buffer holds a burst and the ring has
// room, read bursts when the ring holds a burst and the sink has room.
// Round-robin between the two sides, one command outstanding at a time.
//   clk, reset                 : clock, synchronous active-high reset
//   enable                     : allow new commands; low while idle flushes ring
//   cfg_base/end_addr, cfg_burst_len : ring bounds [base,end) and burst bytes
//   wr_level, rd_space         : source bytes ready / sink bytes free
//   wr_cmd_* / rd_cmd_*        : command handshake + payload per side
//   wr_done, rd_done           : one-cycle burst completion pulses
//   fill_bytes                 : bytes written to the ring and not yet read
//   busy                       : FSM not idle
//   err_spurious               : sticky, done pulse outside its WAIT state
module dma_cmd_scheduler
  import dma_sched_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH      = 13,
  parameter int unsigned LVL_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [AXI_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [AXI_ADDR_WIDTH-1:0] cfg_end_addr,
  input  logic [LEN_WIDTH-1:0]      cfg_burst_len,
  input  logic [LVL_WIDTH-1:0]      wr_level,
  input  logic [LVL_WIDTH-1:0]      rd_space,
  output logic                      wr_cmd_valid,
  input  logic                      wr_cmd_ready,
  output logic [AXI_ADDR_WIDTH-1:0] wr_cmd_addr,
  output logic [LEN_WIDTH-1:0]      wr_cmd_length,
  input  logic                      wr_done,
  output logic                      rd_cmd_valid,
  input  logic                      rd_cmd_ready,
  output logic [AXI_ADDR_WIDTH-1:0] rd_cmd_addr,
  output logic [LEN_WIDTH-1:0]      rd_cmd_length,
  input  logic                      rd_done,
  output logic [AXI_ADDR_WIDTH-1:0] fill_bytes,
  output logic                      busy,
  output logic                      err_spurious
);

  sched_state_t              state_q;
  grant_t                    last_grant_q;
  logic [AXI_ADDR_WIDTH-1:0] fill_q;
  logic                      wr_valid_q, rd_valid_q, busy_q, err_q;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
  logic [LEN_WIDTH-1:0]      wr_len_q, rd_len_q;

  logic [AXI_ADDR_WIDTH-1:0] wr_ptr, rd_ptr, ring_size, burst, level, space;
  logic                      wr_elig, rd_elig, flush, wr_adv, rd_adv;

  assign burst     = AXI_ADDR_WIDTH'(cfg_burst_len);
  assign level     = AXI_ADDR_WIDTH'(wr_level);
  assign space     = AXI_ADDR_WIDTH'(rd_space);
  assign ring_size = cfg_end_addr - cfg_base_addr;

  assign wr_elig = enable && (level >= burst) && ((ring_size - fill_q) >= burst);
  assign rd_elig = enable && (fill_q >= burst) && (space >= burst);

  assign flush  = (state_q == S_IDLE) && !enable;
  assign wr_adv = (state_q == S_WR_WAIT) && wr_done;
  assign rd_adv = (state_q == S_RD_WAIT) && rd_done;

  ring_ptr #(.AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_wr_ptr (
    .clk(clk), .reset(reset), .load(flush), .advance(wr_adv),
    .base_addr(cfg_base_addr), .end_addr(cfg_end_addr), .step(cfg_burst_len),
    .ptr(wr_ptr)
  );

  ring_ptr #(.AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_rd_ptr (
    .clk(clk), .reset(reset), .load(flush), .advance(rd_adv),
    .base_addr(cfg_base_addr), .end_addr(cfg_end_addr), .step(cfg_burst_len),
    .ptr(rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_RD;
      fill_q       <= '0;
      wr_valid_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_len_q     <= '0;
      rd_len_q     <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if ((wr_done && state_q != S_WR_WAIT) || (rd_done && state_q != S_RD_WAIT))
        err_q <= 1'b1;

      unique case (state_q)
        S_IDLE: begin
          // Write wins unless read is also eligible and write had the last grant.
          if (wr_elig && (!rd_elig || last_grant_q == GRANT_RD)) begin
            state_q      <= S_WR_REQ;
            last_grant_q <= GRANT_WR;
            wr_valid_q   <= 1'b1;
            wr_addr_q    <= wr_ptr;
            wr_len_q     <= cfg_burst_len;
            busy_q       <= 1'b1;
          end else if (rd_elig) begin
            state_q      <= S_RD_REQ;
            last_grant_q <= GRANT_RD;
            rd_valid_q   <= 1'b1;
            rd_addr_q    <= rd_ptr;
            rd_len_q     <= cfg_burst_len;
            busy_q       <= 1'b1;
          end else if (!enable) begin
            fill_q <= '0;
          end
        end
        S_WR_REQ: begin
          if (wr_cmd_ready) begin
            wr_valid_q <= 1'b0;
            state_q    <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (wr_done) begin
            fill_q  <= fill_q + burst;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_RD_REQ: begin
          if (rd_cmd_ready) begin
            rd_valid_q <= 1'b0;
            state_q    <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (rd_done) begin
            fill_q  <= fill_q - burst;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_cmd_valid  = wr_valid_q;
  assign wr_cmd_addr   = wr_addr_q;
  assign wr_cmd_length = wr_len_q;
  assign rd_cmd_valid  = rd_valid_q;
  assign rd_cmd_addr   = rd_addr_q;
  assign rd_cmd_length = rd_len_q;
  assign fill_bytes    = fill_q;
  assign busy          = busy_q;
  assign err_spurious  = err_q;

endmodule

// File: doc/dma_cmd_scheduler.md
# dma_cmd_scheduler

Command scheduler that sits in front of the `adma_v1` user command ports and runs DDR as a ring buffer. It issues write bursts when the write-side buffer holds enough data and the ring has room. It issues read bursts when the ring holds written data and the read-side sink has room. Write and read are arbitrated round-robin, with one command outstanding at a time.

## Interface
- `AXI_ADDR_WIDTH`, 32: address width.
- `LEN_WIDTH`, 13: byte-length width. 4096 fits.
- `LVL_WIDTH`, 16: width of the buffer level inputs.
- `clk` in 1: single clock. Both DMA command sides use this clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: allows new commands. Low while idle flushes the ring.
- `cfg_base_addr` in AXI_ADDR_WIDTH: ring start, inclusive.
- `cfg_end_addr` in AXI_ADDR_WIDTH: ring end, exclusive. `end - base` must be a nonzero multiple of `cfg_burst_len`.
- `cfg_burst_len` in LEN_WIDTH: bytes per command, 1..4096.
- `wr_level` in LVL_WIDTH: bytes ready in the write source buffer.
- `rd_space` in LVL_WIDTH: bytes free in the read sink buffer.
- `wr_cmd_valid` out 1, `wr_cmd_ready` in 1: write command handshake.
- `wr_cmd_addr` out AXI_ADDR_WIDTH, `wr_cmd_length` out LEN_WIDTH: write command payload.
- `wr_done` in 1: one-cycle pulse when the write burst response is accepted.
- `rd_cmd_valid` out 1, `rd_cmd_ready` in 1: read command handshake.
- `rd_cmd_addr` out AXI_ADDR_WIDTH, `rd_cmd_length` out LEN_WIDTH: read command payload.
- `rd_done` in 1: one-cycle pulse on the last read beat.
- `fill_bytes` out AXI_ADDR_WIDTH: bytes written to the ring and not yet read.
- `busy` out 1: high whenever the state is not IDLE.
- `err_spurious` out 1: sticky; set by a `wr_done`/`rd_done` pulse received outside the matching WAIT state.

## Operation
- **States:** IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT.
- **Eligibility** (computed from registered state and current inputs):
  - Write is eligible when `enable`, `wr_level >= cfg_burst_len`, and `(end-base) - fill_bytes >= cfg_burst_len` all hold.
  - Read is eligible when `enable`, `fill_bytes >= cfg_burst_len`, and `rd_space >= cfg_burst_len` all hold.
- **IDLE:**
  - Only one side eligible: go to that side's REQ state.
  - Both eligible: grant the side opposite `last_grant`. `last_grant` resets to RD, so write wins the first tie.
  - Update `last_grant` on each grant.
- **WR_REQ / RD_REQ:**
  - Hold valid high with the address and length stable until ready is seen.
  - On the handshake, go to the matching WAIT state.
- **WR_WAIT:** on `wr_done`:
  - `wr_ptr` advances by `cfg_burst_len` with wrap.
  - `fill_bytes` increases by `cfg_burst_len`.
  - Go to IDLE.
- **RD_WAIT:** on `rd_done`:
  - `rd_ptr` advances with wrap.
  - `fill_bytes` decreases by `cfg_burst_len`.
  - Go to IDLE.
- **Wrap rule:** `next = ptr + len`. If `next >= cfg_end_addr`, then `next = cfg_base_addr`. Compute the sum at AXI_ADDR_WIDTH+1 bits so a carry is never lost.
- **Flush:** in IDLE with `enable == 0`, set `wr_ptr <= cfg_base_addr`, `rd_ptr <= cfg_base_addr`, `fill_bytes <= 0` every cycle.
- **Enable dropping mid-command:** the current command completes normally; the block then returns to IDLE and flushes.
- **Config inputs:** must be static while `enable` is high. Changing them then is unsupported.
- **Simultaneous done pulses:** cannot occur legally. Any done pulse arriving outside its WAIT state is ignored for pointers and fill, and sets `err_spurious`.
- **Ring boundaries:**
  - Full ring (`fill_bytes == end-base`) blocks writes.
  - Empty ring blocks reads.
  - `wr_ptr == rd_ptr` is disambiguated by `fill_bytes`.

## Timing
- **Reset values:**
  - valids 0; `busy` 0; `err_spurious` 0; `fill_bytes` 0.
  - `wr_cmd_addr`, `rd_cmd_addr`, and both pointers: 0. Pointers load `cfg_base_addr` on the first flush cycle.
  - lengths 0; state IDLE.
- All outputs are registered.
- **Grant latency:** if eligibility holds in an IDLE cycle N, valid is high in cycle N+1.
- The payload is registered together with valid and does not change while valid is high.
- **Handshake:** ready is sampled on the rising edge. Valid drops in the cycle after the handshake. `ready` arriving before `valid` has no effect.
- **Completion:** a done pulse in WAIT cycle N gives IDLE in N+1, with pointers and `fill_bytes` updated at the same edge. The next valid appears at N+2 at the earliest.
- **Reset mid-command:** all state returns to reset values at the next edge. Any outstanding DMA transfer is the responsibility of the DMA's own reset.

## Structure
- Package `dma_sched_pkg`:
  - state enum `sched_state_t`;
  - grant encoding `GRANT_WR`/`GRANT_RD`;
  - `MAX_BURST_BYTES = 4096`.
- Sub-module `ring_ptr`: holds the pointer register, takes advance and load inputs, and applies the wrap rule. It is instantiated twice, once for write and once for read.

## Test plan
- **Basic write then read:** base `0x0`, end `0x14000`, burst 4096, `wr_level = 4096`, `rd_space = 0`.
  - Write command: addr `0x0`, length 4096.
  - After `wr_done`: `fill_bytes = 4096`.
  - Then set `rd_space = 4096`: read command at addr `0x0`.
- **Round-robin tie:** both sides eligible.
  - Grant order is WR, RD, WR, RD.
  - Addresses are `0x0`, `0x0`, `0x1000`, `0x1000`.
- **Wrap and full:** fill 20 write bursts.
  - The 20th write goes to `0x13000`; `fill_bytes = 0x14000`.
  - The 21st write is blocked while `wr_level` stays high.
  - One read at `0x0` completes; the next write goes to `0x0`.
- **Handshake stall:** `wr_cmd_ready` held low for 5 cycles.
  - valid, addr and length stay stable for all 5 cycles.
  - One command only; `busy` stays high.
- **Spurious done:** `rd_done` pulse in IDLE.
  - `err_spurious` is 1 from the next cycle.
  - `fill_bytes` and pointers are unchanged.
- **Enable drop and reset:** drop `enable` during WR_WAIT.
  - The command completes and the block returns to IDLE.
  - `fill_bytes` returns to 0 and pointers return to base.
  - Assert `reset` during RD_REQ: valid is 0 in the next cycle.
